// File: rtl/frame_pipeline_ctrl.sv
// Frame sequencer driving noise-estimation and Wiener enables/strobes block by block.
// Optional watchdog on rlast / estimated_noise_ready waits: define FRAME_CTRL_WATCHDOG_EN.
module frame_pipeline_ctrl #(
    parameter int unsigned BLOCK_SIZE   = 8,
    parameter int unsigned ROW_GAP      = 4,
    parameter int unsigned NE_TAIL      = 3,
    parameter int unsigned FLUSH_BLOCKS = 2
`ifdef FRAME_CTRL_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES  = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] blocks_per_frame,
    input  logic        frame_ready_for_noise_est,
    input  logic        rlast,
    input  logic        estimated_noise_ready,
    output logic        noise_estimation_en,
    output logic        start_data_noise_est,
    output logic        start_of_frame_noise_estimation,
    output logic        wiener_block_stats_en,
    output logic        wiener_calc_en,
    output logic        start_data_wiener,
    output logic        start_of_frame_wiener,
    output logic        busy,
    output logic [31:0] block_idx,
    output logic        frame_done,
    output logic        timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_NE_START, S_NE_ROW, S_NE_GAP, S_NE_TAIL,
        S_NE_WAIT, S_WI_START, S_WI_ROW, S_WI_GAP, S_DONE
    } state_t;

    localparam logic [31:0] BS_M1   = 32'(BLOCK_SIZE - 1);
    localparam logic [31:0] GAP_M1  = 32'(ROW_GAP - 1);
    localparam logic [31:0] TAIL_M1 = 32'(NE_TAIL - 1);

    state_t      state_q, state_d;
    logic [31:0] nblk_q, nblk_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] row_q, row_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ne_en_q, ne_en_d, sd_ne_q, sd_ne_d, sof_ne_q, sof_ne_d;
    logic        wi_en_q, wi_en_d, sd_wi_q, sd_wi_d, sof_wi_q, sof_wi_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [32:0] idx_inc, slot_lim;

`ifdef FRAME_CTRL_WATCHDOG_EN
    localparam logic [31:0] WD_M1 = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
`endif

    // Slot arithmetic is 33 bits wide so nblk + FLUSH_BLOCKS never wraps.
    assign idx_inc  = {1'b0, idx_q} + 33'd1;
    assign slot_lim = {1'b0, nblk_q} + 33'(FLUSH_BLOCKS);

    always_comb begin
        state_d = state_q;
        nblk_d  = nblk_q;
        idx_d   = idx_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (frame_ready_for_noise_est) begin
                nblk_d  = blocks_per_frame;
                idx_d   = '0;
                row_d   = '0;
                cnt_d   = '0;
                state_d = (blocks_per_frame == '0) ? S_DONE : S_NE_START;
            end
            S_NE_START: state_d = S_NE_ROW;
            S_NE_ROW: if (rlast) begin
                cnt_d = '0;
                if (row_q < BS_M1) begin
                    row_d   = row_q + 32'd1;
                    state_d = S_NE_GAP;
                end else begin
                    state_d = S_NE_TAIL;
                end
            end
            S_NE_GAP: if (cnt_q == GAP_M1) begin
                cnt_d   = '0;
                state_d = S_NE_ROW;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            S_NE_TAIL: if (cnt_q == TAIL_M1) begin
                cnt_d   = '0;
                row_d   = '0;
                idx_d   = idx_q + 32'd1;
                state_d = (idx_inc < {1'b0, nblk_q}) ? S_NE_START : S_NE_WAIT;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            S_NE_WAIT: if (estimated_noise_ready) begin
                idx_d   = '0;
                state_d = S_WI_START;
            end
            S_WI_START: begin
                cnt_d   = '0;
                row_d   = '0;
                state_d = S_WI_ROW;
            end
            S_WI_ROW: if (cnt_q == BS_M1) begin
                cnt_d = '0;
                if (row_q < BS_M1) begin
                    row_d   = row_q + 32'd1;
                    state_d = S_WI_GAP;
                end else begin
                    row_d   = '0;
                    idx_d   = idx_q + 32'd1;
                    state_d = (idx_inc < slot_lim) ? S_WI_START : S_DONE;
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            S_WI_GAP: if (cnt_q == GAP_M1) begin
                cnt_d   = '0;
                state_d = S_WI_ROW;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef FRAME_CTRL_WATCHDOG_EN
        // Watchdog overrides the normal next state; it only counts while a wait persists.
        wdog_d    = '0;
        timeout_d = timeout_q;
        if (state_q == S_IDLE && frame_ready_for_noise_est)
            timeout_d = 1'b0;
        if ((state_q == S_NE_ROW || state_q == S_NE_WAIT) && state_d == state_q) begin
            if (wdog_q == WD_M1) begin
                state_d   = S_IDLE;
                timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end
`endif

        // Outputs are decoded from the next state so they register alongside it.
        ne_en_d  = (state_d == S_NE_START) || (state_d == S_NE_ROW) || (state_d == S_NE_TAIL);
        sd_ne_d  = (state_d == S_NE_START);
        sof_ne_d = (state_d == S_NE_START) && (idx_d == '0);
        wi_en_d  = (state_d == S_WI_START) || (state_d == S_WI_ROW);
        sd_wi_d  = (state_d == S_WI_START) && (idx_d < nblk_d);
        sof_wi_d = (state_d == S_WI_START) && (idx_d == '0);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            nblk_q   <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            ne_en_q  <= 1'b0;
            sd_ne_q  <= 1'b0;
            sof_ne_q <= 1'b0;
            wi_en_q  <= 1'b0;
            sd_wi_q  <= 1'b0;
            sof_wi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FRAME_CTRL_WATCHDOG_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            nblk_q   <= nblk_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            ne_en_q  <= ne_en_d;
            sd_ne_q  <= sd_ne_d;
            sof_ne_q <= sof_ne_d;
            wi_en_q  <= wi_en_d;
            sd_wi_q  <= sd_wi_d;
            sof_wi_q <= sof_wi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef FRAME_CTRL_WATCHDOG_EN
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign noise_estimation_en             = ne_en_q;
    assign start_data_noise_est            = sd_ne_q;
    assign start_of_frame_noise_estimation = sof_ne_q;
    assign wiener_block_stats_en           = wi_en_q;
    assign wiener_calc_en                  = wi_en_q;
    assign start_data_wiener               = sd_wi_q;
    assign start_of_frame_wiener           = sof_wi_q;
    assign busy                            = busy_q;
    assign block_idx                       = idx_q;
    assign frame_done                      = done_q;
`ifdef FRAME_CTRL_WATCHDOG_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_pipeline_ctrl.sv
// Bench for frame_pipeline_ctrl: expected per-cycle timelines built from the frame schedule.
module tb_frame_pipeline_ctrl;

    localparam int unsigned BS = 8, GAP = 4, TAIL = 3, FL = 2, WD = 50;

    localparam logic [9:0] M_NE    = 10'b1000000000;
    localparam logic [9:0] M_SDNE  = 10'b0100000000;
    localparam logic [9:0] M_SOFNE = 10'b0010000000;
    localparam logic [9:0] M_WS    = 10'b0001000000;
    localparam logic [9:0] M_WC    = 10'b0000100000;
    localparam logic [9:0] M_SDW   = 10'b0000010000;
    localparam logic [9:0] M_SOFW  = 10'b0000001000;
    localparam logic [9:0] M_BUSY  = 10'b0000000100;
    localparam logic [9:0] M_FD    = 10'b0000000010;
    localparam logic [9:0] M_TO    = 10'b0000000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] blocks_per_frame = '0;
    logic        frame_ready_for_noise_est = 1'b0;
    logic        rlast = 1'b0;
    logic        estimated_noise_ready = 1'b0;
    logic        noise_estimation_en, start_data_noise_est, start_of_frame_noise_estimation;
    logic        wiener_block_stats_en, wiener_calc_en, start_data_wiener, start_of_frame_wiener;
    logic        busy, frame_done, timeout_err;
    logic [31:0] block_idx;

    always #5 clk = ~clk;

    frame_pipeline_ctrl #(
        .BLOCK_SIZE(BS), .ROW_GAP(GAP), .NE_TAIL(TAIL), .FLUSH_BLOCKS(FL)
`ifdef FRAME_CTRL_WATCHDOG_EN
        , .WDOG_CYCLES(WD)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .blocks_per_frame(blocks_per_frame),
        .frame_ready_for_noise_est(frame_ready_for_noise_est),
        .rlast(rlast), .estimated_noise_ready(estimated_noise_ready),
        .noise_estimation_en(noise_estimation_en),
        .start_data_noise_est(start_data_noise_est),
        .start_of_frame_noise_estimation(start_of_frame_noise_estimation),
        .wiener_block_stats_en(wiener_block_stats_en),
        .wiener_calc_en(wiener_calc_en),
        .start_data_wiener(start_data_wiener),
        .start_of_frame_wiener(start_of_frame_wiener),
        .busy(busy), .block_idx(block_idx),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    int vectors = 0, miscompares = 0;
    int n_sdne, n_sdw, n_sofne, n_sofw, n_fd, n_wien;
    int unsigned mark_t;

    logic [9:0]  e_f[$];
    logic [31:0] e_idx[$];
    bit          e_chk[$];
    bit          i_fr[$], i_rl[$], i_rdy[$];
    logic [31:0] i_bpf[$];

    function automatic logic [9:0] obs_flags();
        return {noise_estimation_en, start_data_noise_est, start_of_frame_noise_estimation,
                wiener_block_stats_en, wiener_calc_en, start_data_wiener,
                start_of_frame_wiener, busy, frame_done, timeout_err};
    endfunction

    function automatic bit nz(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom % 2);
    endfunction

    task automatic clear_trace();
        e_f.delete(); e_idx.delete(); e_chk.delete();
        i_fr.delete(); i_rl.delete(); i_rdy.delete(); i_bpf.delete();
    endtask

    task automatic clear_tally();
        n_sdne = 0; n_sdw = 0; n_sofne = 0; n_sofw = 0; n_fd = 0; n_wien = 0;
    endtask

    task automatic put(input logic [9:0] f, input logic [31:0] idx, input bit chk,
                       input bit rl, input bit fr, input bit rdy);
        e_f.push_back(f); e_idx.push_back(idx); e_chk.push_back(chk);
        i_rl.push_back(rl); i_fr.push_back(fr); i_rdy.push_back(rdy);
        i_bpf.push_back($urandom);
    endtask

    // Frame schedule: dfix=0 picks a random row read length; nmode shapes rlast in ignored cycles.
    task automatic build_frame(input int unsigned nb, input int unsigned dfix,
                               input int unsigned wdelay, input int nmode, input bit frn);
        int unsigned d;
        clear_trace();
        put('0, 0, 0, nz(nmode), 1'b1, 1'b0);
        i_bpf[0] = nb;
        if (nb == 0) begin
            put(M_BUSY | M_FD, 0, 1, nz(nmode), frn & nz(2), nz(2));
        end else begin
            for (int unsigned b = 0; b < nb; b++) begin
                put(M_BUSY | M_NE | M_SDNE | ((b == 0) ? M_SOFNE : '0), b, 1, nz(nmode), frn & nz(2), nz(2));
                for (int unsigned r = 0; r < BS; r++) begin
                    d = (dfix != 0) ? dfix : $urandom_range(1, 9);
                    for (int unsigned j = 0; j < d; j++)
                        put(M_BUSY | M_NE, b, 1, (j == d - 1), frn & nz(2), nz(2));
                    if (r < BS - 1)
                        for (int unsigned j = 0; j < GAP; j++) put(M_BUSY, b, 1, nz(nmode), frn & nz(2), nz(2));
                    else
                        for (int unsigned j = 0; j < TAIL; j++) put(M_BUSY | M_NE, b, 1, nz(nmode), frn & nz(2), nz(2));
                end
            end
            for (int unsigned j = 0; j <= wdelay; j++)
                put(M_BUSY, nb, 1, nz(nmode), frn & nz(2), (j == wdelay));
            for (int unsigned s = 0; s < nb + FL; s++) begin
                if (s == 2) mark_t = e_f.size();
                put(M_BUSY | M_WS | M_WC | ((s < nb) ? M_SDW : '0) | ((s == 0) ? M_SOFW : '0),
                    s, 1, nz(nmode), frn & nz(2), nz(2));
                for (int unsigned r = 0; r < BS; r++) begin
                    for (int unsigned j = 0; j < BS; j++) put(M_BUSY | M_WS | M_WC, s, 1, nz(nmode), frn & nz(2), nz(2));
                    if (r < BS - 1)
                        for (int unsigned j = 0; j < GAP; j++) put(M_BUSY, s, 1, nz(nmode), frn & nz(2), nz(2));
                end
            end
            put(M_BUSY | M_FD, 0, 0, nz(nmode), frn & nz(2), nz(2));
        end
        for (int j = 0; j < 3; j++) put('0, 0, 0, nz(nmode), 1'b0, nz(2));
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_trace(input string name, input int unsigned upto);
        logic [9:0] f;
        for (int unsigned k = 0; k < upto; k++) begin
            frame_ready_for_noise_est = i_fr[k];
            rlast                     = i_rl[k];
            estimated_noise_ready     = i_rdy[k];
            blocks_per_frame          = i_bpf[k];
            f = obs_flags();
            vectors++;
            if (f !== e_f[k] || (e_chk[k] && block_idx !== e_idx[k])) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got flags=%b idx=%0d, expected flags=%b idx=%0d",
                         name, k, f, block_idx, e_f[k], e_idx[k]);
            end
            if (start_data_noise_est) n_sdne++;
            if (start_data_wiener) n_sdw++;
            if (start_of_frame_noise_estimation) n_sofne++;
            if (start_of_frame_wiener) n_sofw++;
            if (frame_done) n_fd++;
            if (wiener_calc_en) n_wien++;
            @(posedge clk); #1;
        end
        frame_ready_for_noise_est = 1'b0;
        rlast = 1'b0;
        estimated_noise_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (obs_flags() !== '0 || block_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got flags=%b idx=%0d, expected all zero", obs_flags(), block_idx);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (obs_flags() !== '0 || block_idx !== '0) begin
            miscompares++;
            $display("FAIL after_reset_idle: got flags=%b idx=%0d, expected all zero", obs_flags(), block_idx);
        end
    endtask

    task automatic test_nominal();
        build_frame(4, 6, 20, 0, 1'b0);
        clear_tally();
        run_trace("nominal", e_f.size());
        vectors++;
        if (n_sdne !== 4) begin miscompares++; $display("FAIL nominal_ne_starts: got %0d, expected 4", n_sdne); end
        vectors++;
        if (n_sdw !== 4) begin miscompares++; $display("FAIL nominal_wi_starts: got %0d, expected 4", n_sdw); end
        vectors++;
        if (n_sofne !== 1 || n_sofw !== 1) begin
            miscompares++; $display("FAIL nominal_sof: got ne=%0d wi=%0d, expected 1 and 1", n_sofne, n_sofw);
        end
        vectors++;
        if (n_fd !== 1) begin miscompares++; $display("FAIL nominal_frame_done: got %0d, expected 1", n_fd); end
        vectors++;
        if (n_wien !== int'((4 + FL) * (BS * BS + 1))) begin
            miscompares++; $display("FAIL nominal_wiener_cycles: got %0d, expected %0d", n_wien, (4 + FL) * (BS * BS + 1));
        end
    endtask

    task automatic test_rlast_ignored();
        build_frame(2, 0, 0, 1, 1'b0);
        clear_tally();
        run_trace("rlast_ignored", e_f.size());
        vectors++;
        if (n_sdne !== 2) begin miscompares++; $display("FAIL rlast_ignored_starts: got %0d, expected 2", n_sdne); end
    endtask

    task automatic test_zero_blocks();
        build_frame(0, 0, 0, 2, 1'b0);
        clear_tally();
        run_trace("zero_blocks", e_f.size());
        vectors++;
        if (n_fd !== 1 || n_sdne !== 0 || n_wien !== 0) begin
            miscompares++;
            $display("FAIL zero_blocks_events: got done=%0d ne=%0d wien=%0d, expected 1 0 0", n_fd, n_sdne, n_wien);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            build_frame($urandom_range(1, 3), 0, $urandom_range(0, 6), 2, 1'b1);
            clear_tally();
            run_trace("back_to_back", e_f.size());
            vectors++;
            if (n_fd !== 1) begin miscompares++; $display("FAIL back_to_back_done: got %0d, expected 1", n_fd); end
        end
    endtask

    task automatic test_reset_mid_frame();
        build_frame(3, 0, 5, 2, 1'b0);
        run_trace("pre_reset", mark_t + 7);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_flags() !== '0 || block_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: got flags=%b idx=%0d, expected all zero", obs_flags(), block_idx);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        build_frame(1, 0, 3, 2, 1'b0);
        clear_tally();
        run_trace("post_reset", e_f.size());
        vectors++;
        if (n_sofne !== 1 || n_fd !== 1) begin
            miscompares++; $display("FAIL post_reset_frame: got sof=%0d done=%0d, expected 1 1", n_sofne, n_fd);
        end
    endtask

    task automatic test_watchdog();
        clear_trace();
        put('0, 0, 0, 1'b0, 1'b1, 1'b0);
        i_bpf[0] = 1;
        put(M_BUSY | M_NE | M_SDNE | M_SOFNE, 0, 1, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_CTRL_WATCHDOG_EN
        for (int j = 0; j < int'(WD); j++) put(M_BUSY | M_NE, 0, 1, 1'b0, 1'b0, 1'b0);
        put(M_TO, 0, 0, 1'b0, 1'b0, 1'b0);
        put(M_TO, 0, 0, 1'b0, 1'b1, 1'b0);
        i_bpf[i_bpf.size() - 1] = 0;
        put(M_BUSY | M_FD, 0, 1, 1'b0, 1'b0, 1'b0);
        put('0, 0, 0, 1'b0, 1'b0, 1'b0);
        clear_tally();
        run_trace("watchdog", e_f.size());
        vectors++;
        if (n_fd !== 1) begin miscompares++; $display("FAIL watchdog_done_count: got %0d, expected 1", n_fd); end
`else
        for (int j = 0; j < 200; j++) put(M_BUSY | M_NE, 0, 1, 1'b0, 1'b0, 1'b0);
        run_trace("no_watchdog", e_f.size());
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (obs_flags() !== '0) begin
            miscompares++; $display("FAIL no_watchdog_reset: got flags=%b, expected all zero", obs_flags());
        end
`endif
    endtask

    task automatic test_random();
        int unsigned nb;
        for (int i = 0; i < 3; i++) begin
            nb = $urandom_range(0, 3);
            build_frame(nb, 0, $urandom_range(0, 25), 2, 1'b1);
            clear_tally();
            run_trace("random", e_f.size());
            vectors++;
            if (n_sdne !== int'(nb) || n_sdw !== int'(nb) || n_fd !== 1) begin
                miscompares++;
                $display("FAIL random_events nb=%0d: got ne=%0d wi=%0d done=%0d, expected %0d %0d 1",
                         nb, n_sdne, n_sdw, n_fd, nb, nb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_rlast_ignored();
        test_zero_blocks();
        test_back_to_back();
        test_reset_mid_frame();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_pipeline_ctrl.md
# frame_pipeline_ctrl

Frame-level sequencer for the denoising pipeline. Once the AXI-stream writer reports a full frame in memory, it drives the noise-estimation and Wiener-filter enable and start strobes block by block and row by row. These strobes are currently hand-generated in benches. The block sits between the AXI-stream memory and the two processing engines, and owns their enables for the whole frame.

## Interface
Parameters:
- BLOCK_SIZE, 8, rows per block and wiener active cycles per row
- ROW_GAP, 4, idle cycles between rows (enables low)
- NE_TAIL, 3, extra enable-high cycles after last row of a block (mean calc)
- FLUSH_BLOCKS, 2, extra Wiener block slots with no start_data, to drain pipeline
- WDOG_CYCLES, 1024, watchdog limit (macro-gated)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset. Asynchronous, active-low.
- blocks_per_frame  in  32  block count, sampled at frame start
- frame_ready_for_noise_est  in  1  frame-in-memory pulse
- rlast  in  1  last beat of a memory row read
- estimated_noise_ready  in  1  noise estimate valid (level)
- noise_estimation_en  out  1  noise engine enable
- start_data_noise_est  out  1  1-cycle block start
- start_of_frame_noise_estimation  out  1  1-cycle, block 0 only
- wiener_block_stats_en  out  1  wiener statistics enable
- wiener_calc_en  out  1  wiener calculation enable
- start_data_wiener  out  1  1-cycle block start (real blocks only)
- start_of_frame_wiener  out  1  1-cycle, block slot 0 only
- busy  out  1  high outside IDLE
- block_idx  out  32  current block index
- frame_done  out  1  1-cycle completion pulse
- timeout_err  out  1  sticky watchdog error

## Operation
- States: IDLE, NE_START, NE_ROW, NE_GAP, NE_TAIL, NE_WAIT, WI_START, WI_ROW, WI_GAP, DONE.

**IDLE**
- On frame_ready_for_noise_est=1: latch blocks_per_frame into nblk, clear block_idx and row_cnt, then go to NE_START.
- If the latched value is 0, go to DONE instead.
- frame_ready pulses in any other state are ignored.

**Noise-estimation phase**
- NE_START (1 cycle): start_data_noise_est=1 and noise_estimation_en=1; start_of_frame_noise_estimation=(block_idx==0). Next state is NE_ROW.
- NE_ROW: noise_estimation_en=1 until rlast is sampled high.
- On rlast, if row_cnt<BLOCK_SIZE-1: row_cnt++ and go to NE_GAP.
- On rlast, if row_cnt==BLOCK_SIZE-1: go to NE_TAIL.
- NE_GAP: enable low for ROW_GAP cycles, then back to NE_ROW.
- NE_TAIL: enable high for NE_TAIL cycles, then block_idx++, row_cnt=0.
  - If block_idx<nblk, go to NE_START.
  - Otherwise go to NE_WAIT with all enables low.
- rlast is examined only in NE_ROW. It is ignored in NE_START, NE_GAP and NE_TAIL.
- NE_WAIT: hold until estimated_noise_ready=1, then clear block_idx and go to WI_START.

**Wiener phase** (nblk+FLUSH_BLOCKS block slots)
- WI_START (1 cycle): stats_en=1 and calc_en=1. start_data_wiener=(block_idx<nblk). start_of_frame_wiener=(block_idx==0).
- WI_ROW: both enables high for BLOCK_SIZE cycles.
- WI_GAP: both enables low for ROW_GAP cycles, then back to WI_ROW. This state is skipped after the last row of a block.
- After the last row of a slot: block_idx++ and go to WI_START.
- After slot nblk+FLUSH_BLOCKS-1 completes, go to DONE.
- DONE: frame_done=1 for 1 cycle, then IDLE.

**Width rule**
- Counters are 32 bits.
- The slot limit nblk+FLUSH_BLOCKS is computed at 33 bits, so it cannot wrap.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame: all enables drop in the same cycle (asynchronous). No frame_done pulse.
- All outputs are registered.
- frame_ready sampled at edge N gives NE_START outputs in cycle N+1.
- rlast sampled at edge N forces noise_estimation_en low from cycle N+1 (goes to NE_GAP) or holds it high (goes to NE_TAIL).
- A wiener row occupies BLOCK_SIZE+1 cycles for row 0 (includes WI_START) and BLOCK_SIZE cycles for later rows.
- Wiener block period = BLOCK_SIZE·BLOCK_SIZE+1+(BLOCK_SIZE-1)·ROW_GAP cycles, i.e. 93 with defaults.
- estimated_noise_ready already high on NE_WAIT entry: WI_START follows the next cycle.

## Configuration
- FRAME_CTRL_WATCHDOG_EN defined:
  - A counter runs in NE_ROW and NE_WAIT and clears on state exit.
  - If it reaches WDOG_CYCLES, timeout_err is set, all enables drop and the FSM returns to IDLE with no frame_done pulse.
  - timeout_err clears only on reset or on the next accepted frame_ready.
- FRAME_CTRL_WATCHDOG_EN undefined:
  - No counter is built and timeout_err is tied 0.
  - The FSM waits indefinitely for rlast and estimated_noise_ready.

## Test plan
- blocks_per_frame=4, rlast 6 cycles after each row enable, noise_ready 20 cycles after NE_WAIT:
  - exactly 4 start_data_noise_est and 32 rlast accepted;
  - 6 wiener slots, with start_data_wiener in slots 0–3 only;
  - start_of_frame strobes in block 0 only;
  - one frame_done.
- rlast held high during NE_GAP and NE_START: ignored; row count stays 8 per block.
- blocks_per_frame=0: frame_done one cycle after frame_ready; no enables ever assert.
- Reset asserted during wiener slot 2: all outputs 0 immediately; next frame_ready restarts at block 0 with start_of_frame.
- Second frame_ready pulse while busy: ignored, and exactly one frame_done.
- With FRAME_CTRL_WATCHDOG_EN and WDOG_CYCLES=50, rlast withheld: timeout_err=1 at cycle 50 of NE_ROW, busy=0, no frame_done. Without the macro, busy stays 1.
